// File: rtl/combo_lock_fsm.sv
// rtl/combo_lock_fsm.sv - keypad combination lock with fail counting and timed lockout
module combo_lock_fsm #(
  parameter int CODE_LEN       = 4,
  parameter int KEY_W          = 4,
  parameter logic [KEY_W*CODE_LEN-1:0] CODE = 16'h1234,
  parameter int MAX_FAIL       = 3,
  parameter int OPEN_CYCLES    = 100,
  parameter int LOCKOUT_CYCLES = 200
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            key_pulse,
  input  logic [KEY_W-1:0]                key_code,
  input  logic                            clear_pulse,
  input  logic                            lock_pulse,
  output logic                            unlocked,
  output logic                            error,
  output logic                            locked_out,
  output logic [$clog2(CODE_LEN+1)-1:0]   digits_entered
);

  localparam int CNT_W   = $clog2(CODE_LEN + 1);
  localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
  localparam int T_MAX   = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TIMER_W = $clog2(T_MAX + 1);

  localparam logic [1:0] S_ENTRY   = 2'd0;
  localparam logic [1:0] S_OPEN    = 2'd1;
  localparam logic [1:0] S_FAIL    = 2'd2;
  localparam logic [1:0] S_LOCKOUT = 2'd3;

  localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(CODE_LEN - 1);
  localparam logic [FAIL_W-1:0]  FAIL_MAX = FAIL_W'(MAX_FAIL);
  localparam logic [TIMER_W-1:0] T_OPEN   = TIMER_W'(OPEN_CYCLES);
  localparam logic [TIMER_W-1:0] T_LOCK   = TIMER_W'(LOCKOUT_CYCLES);
  localparam logic [TIMER_W-1:0] T_ONE    = TIMER_W'(1);

  logic [1:0]         state;
  logic [CNT_W-1:0]   count;
  logic               mismatch;
  logic [FAIL_W-1:0]  fail_cnt;
  logic [TIMER_W-1:0] timer;

  // Digit table padded to the full index range so count can address it directly.
  logic [KEY_W-1:0] code_arr [2**CNT_W];
  for (genvar g = 0; g < 2**CNT_W; g++) begin : g_code
    if (g < CODE_LEN) begin : g_used
      assign code_arr[g] = CODE[KEY_W*(CODE_LEN-g)-1 -: KEY_W];
    end else begin : g_pad
      assign code_arr[g] = '0;
    end
  end

  logic              digit_bad;
  logic [FAIL_W-1:0] fail_next;
  assign digit_bad = (key_code != code_arr[count]);
  assign fail_next = (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_ENTRY;
      count    <= '0;
      mismatch <= 1'b0;
      fail_cnt <= '0;
      timer    <= '0;
    end else begin
      case (state)
        S_ENTRY: begin
          if (clear_pulse) begin
            count    <= '0;
            mismatch <= 1'b0;
          end else if (key_pulse) begin
            if (count == LAST_IDX) begin
              count    <= '0;
              mismatch <= 1'b0;
              if (!mismatch && !digit_bad) begin
                state    <= S_OPEN;
                fail_cnt <= '0;
                timer    <= T_OPEN;
              end else begin
                fail_cnt <= fail_next;
                if (fail_next == FAIL_MAX) begin
                  state <= S_LOCKOUT;
                  timer <= T_LOCK;
                end else begin
                  state <= S_FAIL;
                end
              end
            end else begin
              count    <= count + 1'b1;
              mismatch <= mismatch | digit_bad;
            end
          end
        end
        S_OPEN: begin
          if (lock_pulse || timer == T_ONE) begin
            state <= S_ENTRY;
            timer <= '0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_FAIL: state <= S_ENTRY;
        S_LOCKOUT: begin
          if (timer == T_ONE) begin
            state    <= S_ENTRY;
            fail_cnt <= '0;
            timer    <= '0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= S_ENTRY;
      endcase
    end
  end

  assign unlocked       = (state == S_OPEN);
  assign error          = (state == S_FAIL);
  assign locked_out     = (state == S_LOCKOUT);
  assign digits_entered = count;

endmodule

// File: tb/tb_combo_lock_fsm.sv
// tb/tb_combo_lock_fsm.sv - directed bench for combo_lock_fsm with a queue-based reference model
module tb_combo_lock_fsm;

  localparam int CODE_LEN = 4;
  localparam int MAX_FAIL = 3;
  localparam int OPEN_C   = 100;
  localparam int LOCK_C   = 200;
  localparam logic [15:0] CODE_V = 16'h1234;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_pulse = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       clear_pulse = 1'b0;
  logic       lock_pulse = 1'b0;
  logic       unlocked, error, locked_out;
  logic [2:0] digits_entered;

  int n_vec = 0;
  int n_err = 0;

  combo_lock_fsm dut (
    .clk(clk), .reset(reset), .key_pulse(key_pulse), .key_code(key_code),
    .clear_pulse(clear_pulse), .lock_pulse(lock_pulse), .unlocked(unlocked),
    .error(error), .locked_out(locked_out), .digits_entered(digits_entered)
  );

  always #5 clk = ~clk;

  // Reference model: digits collected in a queue, remaining open/lockout cycles as plain counts.
  int m_got[$];
  int m_open_left = 0;
  int m_lock_left = 0;
  int m_fails = 0;
  bit m_err = 1'b0;

  function automatic int code_digit(input int i);
    logic [15:0] c;
    c = CODE_V >> (4 * (CODE_LEN - 1 - i));
    return int'(c[3:0]);
  endfunction

  task automatic model_step();
    bit ok;
    if (reset) begin
      m_got.delete();
      m_open_left = 0; m_lock_left = 0; m_fails = 0; m_err = 1'b0;
    end else if (m_open_left > 0) begin
      m_open_left = lock_pulse ? 0 : m_open_left - 1;
    end else if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fails = 0;
    end else if (m_err) begin
      m_err = 1'b0;
    end else if (clear_pulse) begin
      m_got.delete();
    end else if (key_pulse) begin
      m_got.push_back(int'(key_code));
      if (m_got.size() == CODE_LEN) begin
        ok = 1'b1;
        for (int i = 0; i < CODE_LEN; i++) if (m_got[i] != code_digit(i)) ok = 1'b0;
        m_got.delete();
        if (ok) begin
          m_open_left = OPEN_C;
          m_fails = 0;
        end else begin
          if (m_fails < MAX_FAIL) m_fails++;
          if (m_fails == MAX_FAIL) m_lock_left = LOCK_C;
          else m_err = 1'b1;
        end
      end
    end
  endtask

  always @(posedge clk or posedge reset) model_step();

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    check("m_unlocked", int'(unlocked), int'(m_open_left > 0));
    check("m_locked_out", int'(locked_out), int'(m_lock_left > 0));
    check("m_error", int'(error), int'(m_err));
    check("m_digits", int'(digits_entered), m_got.size());
  end

  task automatic press(input int d);
    key_pulse = 1'b1;
    key_code  = 4'(d);
    @(negedge clk);
    key_pulse = 1'b0;
  endtask

  task automatic enter(input int a, input int b, input int c, input int d);
    press(a); press(b); press(c); press(d);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic relock();
    lock_pulse = 1'b1;
    @(negedge clk);
    lock_pulse = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_unlocked"}, int'(unlocked), 0);
    check({tag, "_error"}, int'(error), 0);
    check({tag, "_locked_out"}, int'(locked_out), 0);
    check({tag, "_digits"}, int'(digits_entered), 0);
  endtask

  int cnt;

  initial begin
    idle(2);
    check_zero("reset");
    reset = 1'b0;
    idle(1);

    // Correct code, digit count steps and exact open length
    press(1); check("dig1", int'(digits_entered), 1);
    press(2); check("dig2", int'(digits_entered), 2);
    press(3); check("dig3", int'(digits_entered), 3);
    press(4); check("dig4", int'(digits_entered), 0);
    check("open_now", int'(unlocked), 1);
    cnt = 0;
    while (unlocked && cnt < 300) begin cnt++; @(negedge clk); end
    check("open_len", cnt, 100);
    idle(1);

    // Relock 10 cycles in; keys while open are ignored
    enter(1, 2, 3, 4);
    idle(4);
    press(1); press(2);
    check("open_keys", int'(digits_entered), 0);
    idle(3);
    relock();
    check("relock", int'(unlocked), 0);
    idle(1);

    // Wrong code then correct code clears the fail count
    enter(1, 2, 3, 5);
    check("wrong_err", int'(error), 1);
    check("wrong_unl", int'(unlocked), 0);
    idle(1);
    check("err_one", int'(error), 0);
    enter(1, 2, 3, 4);
    check("after_wrong_open", int'(unlocked), 1);
    relock();
    enter(9, 2, 3, 4); idle(1);
    enter(1, 2, 3, 5);
    check("fail2_err", int'(error), 1);
    check("fail2_nolock", int'(locked_out), 0);
    idle(1);

    // Third consecutive failure locks out; all strobes ignored throughout
    enter(1, 1, 1, 1);
    check("lock_on", int'(locked_out), 1);
    check("lock_noerr", int'(error), 0);
    cnt = 0;
    while (locked_out && cnt < 400) begin
      key_pulse   = (cnt % 7 == 0);
      clear_pulse = (cnt % 11 == 3);
      lock_pulse  = (cnt % 13 == 5);
      key_code    = 4'(cnt);
      @(negedge clk);
      cnt++;
    end
    key_pulse = 1'b0; clear_pulse = 1'b0; lock_pulse = 1'b0;
    check("lock_len", cnt, 200);
    check("lock_digits", int'(digits_entered), 0);
    enter(1, 2, 3, 4);
    check("post_lock_open", int'(unlocked), 1);
    relock();

    // Clear mid-entry, then clear colliding with a key
    press(1); press(2);
    clear_pulse = 1'b1; @(negedge clk); clear_pulse = 1'b0;
    check("clear", int'(digits_entered), 0);
    enter(1, 2, 3, 4);
    check("clear_open", int'(unlocked), 1);
    relock();
    clear_pulse = 1'b1; key_pulse = 1'b1; key_code = 4'd1;
    @(negedge clk);
    clear_pulse = 1'b0; key_pulse = 1'b0;
    check("clear_wins", int'(digits_entered), 0);

    // Async reset mid-OPEN
    enter(1, 2, 3, 4);
    idle(5);
    #2 reset = 1'b1;
    #1 check_zero("rst_open");
    @(negedge clk); reset = 1'b0;
    idle(1);

    // Async reset mid-LOCKOUT, then fail count must restart from zero
    enter(1, 2, 3, 5); idle(1);
    enter(1, 2, 3, 5); idle(1);
    enter(1, 2, 3, 5);
    idle(50);
    check("lock_mid", int'(locked_out), 1);
    #2 reset = 1'b1;
    #1 check_zero("rst_lock");
    @(negedge clk); reset = 1'b0;
    idle(1);
    enter(7, 7, 7, 7); idle(1);
    enter(7, 7, 7, 7);
    check("rst_fail_cleared", int'(locked_out), 0);
    check("rst_fail_err", int'(error), 1);
    idle(2);
    enter(1, 2, 3, 4);
    check("final_open", int'(unlocked), 1);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
